// File: rtl/fetch_req_ctrl_pkg.sv
// rtl/fetch_req_ctrl_pkg.sv - shared fetch definitions: state encodings, reset PC, transfer size
package fetch_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

endpackage

// File: rtl/fetch_req_ctrl_if.sv
// rtl/fetch_req_ctrl_if.sv - SRAM-like instruction port with addr_ok/data_ok handshake
interface fetch_req_ctrl_if;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

endinterface

// File: rtl/fetch_redirect_sel.sv
// rtl/fetch_redirect_sel.sv - redirect priority mux, exception redirect beats branch
module fetch_redirect_sel (
  input  logic        ex_flush,
  input  logic [31:0] ex_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        redirect,
  output logic [31:0] target
);

  // Exception/ertn redirect has priority over a branch in the same cycle.
  always_comb begin
    redirect = ex_flush | br_taken;
    target   = ex_flush ? ex_entry : br_target;
  end

endmodule

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - fetch request controller; optional FETCH_ADEF_CHECK_EN address-error check
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_flush,
  input  logic [31:0]             ex_entry,
  input  logic                    br_taken,
  input  logic [31:0]             br_target,
  input  logic                    fs_allowin,
  fetch_req_ctrl_if.master        sram,
  output logic                    fs_valid,
  output logic [31:0]             fs_pc,
  output logic [31:0]             fs_inst,
  output logic                    fs_adef
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  req_pc, req_pc_nxt;
  logic         cancel, cancel_nxt;
  logic         fs_valid_nxt;
  logic [31:0]  fs_pc_nxt;
  logic [31:0]  fs_inst_nxt;
  logic         fs_adef_nxt;
  logic         redirect;
  logic [31:0]  target;
  logic         addr_err;

  fetch_redirect_sel u_redirect_sel (
    .ex_flush  (ex_flush),
    .ex_entry  (ex_entry),
    .br_taken  (br_taken),
    .br_target (br_target),
    .redirect  (redirect),
    .target    (target)
  );

`ifdef FETCH_ADEF_CHECK_EN
  assign addr_err = (pc[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  // Request is decoded from state and the pc register only, never from redirect inputs.
  assign sram.inst_sram_req   = (state == ST_REQ) && !addr_err;
  assign sram.inst_sram_addr  = pc;
  assign sram.inst_sram_wr    = 1'b0;
  assign sram.inst_sram_size  = SIZE_WORD;
  assign sram.inst_sram_wstrb = 4'h0;
  assign sram.inst_sram_wdata = 32'h0;

  // Next-state, PC tracking, cancel bookkeeping and output buffer update.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_pc_nxt   = req_pc;
    cancel_nxt   = cancel;
    fs_valid_nxt = fs_valid;
    fs_pc_nxt    = fs_pc;
    fs_inst_nxt  = fs_inst;
    fs_adef_nxt  = fs_adef;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (addr_err) begin
          // Misaligned fetch is never issued; a redirect can still rescue it.
          if (redirect) begin
            pc_nxt = target;
          end else begin
            state_nxt    = ST_HOLD;
            fs_valid_nxt = 1'b1;
            fs_pc_nxt    = pc;
            fs_inst_nxt  = 32'h0;
            fs_adef_nxt  = 1'b1;
          end
        end else if (sram.inst_sram_addr_ok) begin
          state_nxt = ST_WAIT;
          if (redirect) begin
            // Accepted request is already wrong-path; its response must be dropped.
            pc_nxt     = target;
            cancel_nxt = 1'b1;
          end else begin
            req_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
          end
        end else if (redirect) begin
          pc_nxt = target;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_nxt     = target;
          cancel_nxt = 1'b1;
        end
        if (sram.inst_sram_data_ok) begin
          state_nxt = (cancel || redirect) ? ST_REQ : ST_HOLD;
          if (cancel || redirect) begin
            cancel_nxt = 1'b0;
          end else begin
            fs_valid_nxt = 1'b1;
            fs_pc_nxt    = req_pc;
            fs_inst_nxt  = sram.inst_sram_rdata;
            fs_adef_nxt  = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          fs_valid_nxt = 1'b0;
          pc_nxt       = target;
          state_nxt    = ST_REQ;
        end else if (fs_allowin) begin
          fs_valid_nxt = 1'b0;
          state_nxt    = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and output buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      cancel   <= 1'b0;
      fs_valid <= 1'b0;
      fs_pc    <= 32'h0;
      fs_inst  <= 32'h0;
      fs_adef  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_pc   <= req_pc_nxt;
      cancel   <= cancel_nxt;
      fs_valid <= fs_valid_nxt;
      fs_pc    <= fs_pc_nxt;
      fs_inst  <= fs_inst_nxt;
      fs_adef  <= fs_adef_nxt;
    end
  end

endmodule
